// File: rtl/game_pkg.sv
// Shared types and default sizing for the number-guessing game (target generator and judge).
// Constants only; no logic, no latency, no flow control.
package game_pkg;

    localparam int N_DEF         = 6;
    localparam int MAX_TRIES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        HIT  = 2'd3
    } result_t;

endpackage

// File: rtl/guess_cmp.sv
// Unsigned compare of a guess against the latched target.
// Purely combinational, zero latency; always produces LOW, HIGH or HIT.
module guess_cmp
    import game_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] guess,
    input  logic [N-1:0] target,
    output result_t      result
);

    always_comb begin
        result = HIT;
        if (guess > target) begin
            result = HIGH;
        end else if (guess < target) begin
            result = LOW;
        end
    end

endmodule

// File: rtl/guess_judge.sv
// Judges player guesses against a PRBS target captured on start; tracks attempts and a saturating win score.
// All outputs registered, judgement one cycle after accept; guess_ready is high only in PLAY.
module guess_judge
    import game_pkg::*;
#(
    parameter  int N         = N_DEF,
    parameter  int MAX_TRIES = MAX_TRIES_DEF,
    localparam int CW        = $clog2(MAX_TRIES + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [N-1:0]  target,
    input  logic          guess_valid,
    input  logic [N-1:0]  guess,
    output logic          guess_ready,
    output logic          result_valid,
    output logic          too_high,
    output logic          too_low,
    output logic          hit,
    output logic [CW-1:0] attempts,
    output logic          game_over,
    output logic          lose,
    output logic [7:0]    wins,
    output logic [N-1:0]  reveal
);

    state_t         state;
    logic [N-1:0]   target_q;
    result_t        cmp_res;
    logic           accept;
    logic [CW-1:0]  att_next;
    logic           last_try;

    guess_cmp #(.N(N)) u_cmp (
        .guess  (guess),
        .target (target_q),
        .result (cmp_res)
    );

    // guess_ready mirrors state==PLAY, so it can stand in for the state test here.
    assign accept   = guess_valid & guess_ready & ~start;
    assign att_next = attempts + 1'b1;
    assign last_try = (att_next == CW'(MAX_TRIES));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            target_q     <= '0;
            guess_ready  <= 1'b0;
            result_valid <= 1'b0;
            too_high     <= 1'b0;
            too_low      <= 1'b0;
            hit          <= 1'b0;
            attempts     <= '0;
            game_over    <= 1'b0;
            lose         <= 1'b0;
            wins         <= '0;
            reveal       <= '0;
        end else begin
            result_valid <= 1'b0;
            if (start) begin
                state       <= PLAY;
                target_q    <= target;
                guess_ready <= 1'b1;
                too_high    <= 1'b0;
                too_low     <= 1'b0;
                hit         <= 1'b0;
                attempts    <= '0;
                game_over   <= 1'b0;
                lose        <= 1'b0;
                reveal      <= '0;
            end else begin
                unique case (state)
                    PLAY: begin
                        if (accept) begin
                            result_valid <= 1'b1;
                            attempts     <= att_next;
                            too_high     <= (cmp_res == HIGH);
                            too_low      <= (cmp_res == LOW);
                            hit          <= (cmp_res == HIT);
                            // A hit on the final attempt is a win, so test HIT first.
                            if (cmp_res == HIT) begin
                                state       <= WIN;
                                guess_ready <= 1'b0;
                                game_over   <= 1'b1;
                                reveal      <= target_q;
                                if (wins != 8'hFF) begin
                                    wins <= wins + 8'd1;
                                end
                            end else if (last_try) begin
                                state       <= LOSE;
                                guess_ready <= 1'b0;
                                game_over   <= 1'b1;
                                lose        <= 1'b1;
                                reveal      <= target_q;
                            end
                        end
                    end
                    IDLE, WIN, LOSE: begin
                        state <= state;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_judge.sv
// Self-checking bench for guess_judge: vector table plus hand sequences, results scored through a queue.
module tb_guess_judge;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [5:0] target;
    logic       guess_valid;
    logic [5:0] guess;
    logic       guess_ready;
    logic       result_valid;
    logic       too_high;
    logic       too_low;
    logic       hit;
    logic [3:0] attempts;
    logic       game_over;
    logic       lose;
    logic [7:0] wins;
    logic [5:0] reveal;

    int checks   = 0;
    int failures = 0;

    // flags are {too_high, too_low, hit}
    typedef struct {
        logic       st;
        logic [5:0] tgt;
        logic       gv;
        logic [5:0] g;
        logic       rv;
        logic [2:0] flags;
        logic [3:0] att;
        logic       go;
        logic       ls;
        logic [7:0] wn;
        logic [5:0] rev;
        logic       rdy;
    } vec_t;

    typedef struct {
        logic [2:0] flags;
        logic [3:0] att;
        logic       go;
        logic       ls;
        logic [7:0] wn;
        logic [5:0] rev;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[11];
    int   w;

    guess_judge dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .target       (target),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_ready  (guess_ready),
        .result_valid (result_valid),
        .too_high     (too_high),
        .too_low      (too_low),
        .hit          (hit),
        .attempts     (attempts),
        .game_over    (game_over),
        .lose         (lose),
        .wins         (wins),
        .reveal       (reveal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [5:0] tgt, input logic gv,
                                input logic [5:0] g, input logic rv, input logic [2:0] flags,
                                input logic [3:0] att, input logic go, input logic ls,
                                input logic [7:0] wn, input logic [5:0] rev, input logic rdy);
        vec_t v;
        v.st = st; v.tgt = tgt; v.gv = gv; v.g = g; v.rv = rv; v.flags = flags;
        v.att = att; v.go = go; v.ls = ls; v.wn = wn; v.rev = rev; v.rdy = rdy;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        sb_t e;
        @(negedge clock);
        start       = v.st;
        target      = v.tgt;
        guess_valid = v.gv;
        guess       = v.g;
        if (v.rv) begin
            e.flags = v.flags; e.att = v.att; e.go = v.go;
            e.ls = v.ls; e.wn = v.wn; e.rev = v.rev;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        chk("result_valid", 32'(result_valid), 32'(v.rv));
        chk("flags",        32'({too_high, too_low, hit}), 32'(v.flags));
        chk("attempts",     32'(attempts), 32'(v.att));
        chk("game_over",    32'(game_over), 32'(v.go));
        chk("lose",         32'(lose), 32'(v.ls));
        chk("wins",         32'(wins), 32'(v.wn));
        chk("reveal",       32'(reveal), 32'(v.rev));
        chk("guess_ready",  32'(guess_ready), 32'(v.rdy));
        start       = 1'b0;
        guess_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n     = 1'b0;
        start       = 1'b0;
        guess_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_outputs", 32'({guess_ready, result_valid, too_high, too_low, hit,
                                attempts, game_over, lose}), 32'd0);
        chk("rst_wins",    32'(wins), 32'd0);
        chk("rst_reveal",  32'(reveal), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Scoreboard side: every result_valid pulse must match the oldest pushed expectation.
    initial begin
        sb_t e;
        forever begin
            @(posedge clock);
            #1;
            if (result_valid === 1'b1) begin
                chk("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_flags",     32'({too_high, too_low, hit}), 32'(e.flags));
                    chk("sb_attempts",  32'(attempts), 32'(e.att));
                    chk("sb_game_over", 32'(game_over), 32'(e.go));
                    chk("sb_lose",      32'(lose), 32'(e.ls));
                    chk("sb_wins",      32'(wins), 32'(e.wn));
                    chk("sb_reveal",    32'(reveal), 32'(e.rev));
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        target      = '0;
        guess_valid = 1'b0;
        guess       = '0;

        tbl[0]  = mk(1, 37, 0,  0, 0, 3'b000, 0, 0, 0, 0,  0, 1);
        tbl[1]  = mk(0,  0, 1, 20, 1, 3'b010, 1, 0, 0, 0,  0, 1);
        tbl[2]  = mk(0,  0, 1, 50, 1, 3'b100, 2, 0, 0, 0,  0, 1);
        tbl[3]  = mk(0,  0, 1, 37, 1, 3'b001, 3, 1, 0, 1, 37, 0);
        tbl[4]  = mk(0,  0, 1, 37, 0, 3'b001, 3, 1, 0, 1, 37, 0);
        tbl[5]  = mk(1,  0, 0,  0, 0, 3'b000, 0, 0, 0, 1,  0, 1);
        tbl[6]  = mk(0,  0, 1,  0, 1, 3'b001, 1, 1, 0, 2,  0, 0);
        tbl[7]  = mk(1, 63, 0,  0, 0, 3'b000, 0, 0, 0, 2,  0, 1);
        tbl[8]  = mk(0,  0, 1, 62, 1, 3'b010, 1, 0, 0, 2,  0, 1);
        tbl[9]  = mk(1, 10, 1, 10, 0, 3'b000, 0, 0, 0, 2,  0, 1);
        tbl[10] = mk(0,  0, 1, 10, 1, 3'b001, 1, 1, 0, 3, 10, 0);

        do_reset();
        for (int i = 0; i < 11; i++) apply(tbl[i]);
        w = 3;

        // Eight misses exhaust the round; a ninth offer is ignored.
        apply(mk(1, 5, 0, 0, 0, 3'b000, 0, 0, 0, 8'(w), 0, 1));
        for (int k = 1; k <= 8; k++) begin
            apply(mk(0, 0, 1, 6, 1, 3'b100, 4'(k), k == 8, k == 8, 8'(w),
                     (k == 8) ? 6'd5 : 6'd0, k != 8));
        end
        apply(mk(0, 0, 1, 6, 0, 3'b100, 8, 1, 1, 8'(w), 5, 0));

        // Hit on the final allowed attempt is a win.
        apply(mk(1, 5, 0, 0, 0, 3'b000, 0, 0, 0, 8'(w), 0, 1));
        for (int k = 1; k <= 7; k++) begin
            apply(mk(0, 0, 1, 4, 1, 3'b010, 4'(k), 0, 0, 8'(w), 0, 1));
        end
        w++;
        apply(mk(0, 0, 1, 5, 1, 3'b001, 8, 1, 0, 8'(w), 5, 0));

        // Guess while in IDLE after reset has no effect.
        do_reset();
        apply(mk(0, 0, 1, 17, 0, 3'b000, 0, 0, 0, 0, 0, 0));

        // Score saturation over 256 wins.
        w = 0;
        for (int r = 0; r < 256; r++) begin
            apply(mk(1, 6'(r), 0, 0, 0, 3'b000, 0, 0, 0, 8'(w), 0, 1));
            if (w < 255) w++;
            apply(mk(0, 0, 1, 6'(r), 1, 3'b001, 1, 1, 0, 8'(w), 6'(r), 0));
        end
        chk("wins_saturated", 32'(wins), 32'd255);

        // Reset in the middle of a round clears everything, wins included.
        apply(mk(1, 9, 0, 0, 0, 3'b000, 0, 0, 0, 8'(w), 0, 1));
        apply(mk(0, 0, 1, 1, 1, 3'b010, 1, 0, 0, 8'(w), 0, 1));
        do_reset();

        repeat (2) @(posedge clock);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
